// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the register file / scoreboard slice.
//   DATA_W_DEF  : default register width
//   ADDR_W_DEF  : default register index width
//   depth_f()   : number of registers for a given index width
//   reg_idx_t   : register index type at the default width
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Register count implied by an index width.
  function automatic int depth_f(input int addr_w);
    return 1 << addr_w;
  endfunction

  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard_if
// Bundles the read, write and reservation signals of the register file.
//   master : issue/decode/writeback side (drives indices, write data, reserve)
//   slave  : the register file itself (returns data, busy flags, ResvOk, count)
// Signals:
//   RS, RT          read indices          dataRS, dataRT  read data
//   busyRS, busyRT  reservation flags     RD, dataRD, RW  write port
//   ResvEn, ResvAddr reservation request  ResvOk          reservation accepted
//   busyCount       number of reserved registers
// -----------------------------------------------------------------------------
interface regfile_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  logic [ADDR_W-1:0] RS;
  logic [ADDR_W-1:0] RT;
  logic [DATA_W-1:0] dataRS;
  logic [DATA_W-1:0] dataRT;
  logic              busyRS;
  logic              busyRT;
  logic [ADDR_W-1:0] RD;
  logic [DATA_W-1:0] dataRD;
  logic              RW;
  logic              ResvEn;
  logic [ADDR_W-1:0] ResvAddr;
  logic              ResvOk;
  logic [ADDR_W:0]   busyCount;

  modport master (
    output RS, RT, RD, dataRD, RW, ResvEn, ResvAddr,
    input  dataRS, dataRT, busyRS, busyRT, ResvOk, busyCount
  );

  modport slave (
    input  RS, RT, RD, dataRD, RW, ResvEn, ResvAddr,
    output dataRS, dataRT, busyRS, busyRT, ResvOk, busyCount
  );

endinterface

// File: rtl/regfile_busy_table.sv
// -----------------------------------------------------------------------------
// regfile_busy_table
// Per-register busy bits for the register file scoreboard.
//   Clk            clock, rising edge
//   Clr            synchronous active-high clear
//   wr_en_i        qualified write (already excludes Clr and hardwired reg 0)
//   wr_addr_i      register being written
//   resv_en_i      reservation request
//   resv_addr_i    register to reserve
//   resv_ok_o      reservation accepted this cycle (combinational)
//   busy_o         busy bit vector, one per register
//   busy_count_o   number of busy bits currently set
// -----------------------------------------------------------------------------
module regfile_busy_table
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                        Clk,
  input  logic                        Clr,
  input  logic                        wr_en_i,
  input  logic [ADDR_W-1:0]           wr_addr_i,
  input  logic                        resv_en_i,
  input  logic [ADDR_W-1:0]           resv_addr_i,
  output logic                        resv_ok_o,
  output logic [depth_f(ADDR_W)-1:0]  busy_o,
  output logic [ADDR_W:0]             busy_count_o
);

  localparam int DEPTH = depth_f(ADDR_W);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  busy_count_q, busy_count_d;
  logic             resv_set;
  logic             wr_clears;

  // A busy register may still be reserved when the same cycle's writeback
  // releases it, so back-to-back producers of one register need no bubble.
  always_comb begin
    resv_ok_o = resv_en_i & ~Clr &
                (~busy_q[resv_addr_i] | (wr_en_i & (wr_addr_i == resv_addr_i)));
  end

  // The hardwired zero register accepts reservations but never tracks them.
  always_comb begin
    resv_set  = resv_ok_o & ~(ZERO_REG && (resv_addr_i == '0));
    wr_clears = wr_en_i & busy_q[wr_addr_i];
  end

  // Clear first, then set, so a same-register write+reserve leaves it busy.
  // resv_set always adds one reservation (either a fresh bit, or a bit that
  // this cycle's write releases, which wr_clears subtracts again).
  always_comb begin
    busy_d = busy_q;
    if (wr_en_i) begin
      busy_d[wr_addr_i] = 1'b0;
    end
    if (resv_set) begin
      busy_d[resv_addr_i] = 1'b1;
    end
    busy_count_d = busy_count_q
                 + {{ADDR_W{1'b0}}, resv_set}
                 - {{ADDR_W{1'b0}}, wr_clears};
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  assign busy_o       = busy_q;
  assign busy_count_o = busy_count_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
// Parametrised register file with two combinational read ports, one
// synchronous write port, optional hardwired-zero register 0, optional
// same-cycle write-to-read bypass, and a busy-bit scoreboard for issue/decode.
//   Clk   clock, rising edge
//   Clr   synchronous active-high clear of data, busy bits and busyCount
//   bus   regfile_scoreboard_if.slave:
//           RS/RT -> dataRS/dataRT, busyRS/busyRT   (read ports)
//           RD, dataRD, RW                          (write port)
//           ResvEn, ResvAddr -> ResvOk              (reservation)
//           busyCount                               (reserved register count)
// -----------------------------------------------------------------------------
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                 Clk,
  input  logic                 Clr,
  regfile_scoreboard_if.slave  bus
);

  localparam int DEPTH = depth_f(ADDR_W);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_vec;
  logic              wr_en;

  // Writes to the hardwired zero register are dropped here so neither the
  // data array nor the busy table ever sees them.
  always_comb begin
    wr_en = bus.RW & ~Clr & ~(ZERO_REG && (bus.RD == '0));
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[bus.RD] <= bus.dataRD;
    end
  end

  regfile_busy_table #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_busy (
    .Clk          (Clk),
    .Clr          (Clr),
    .wr_en_i      (wr_en),
    .wr_addr_i    (bus.RD),
    .resv_en_i    (bus.ResvEn),
    .resv_addr_i  (bus.ResvAddr),
    .resv_ok_o    (bus.ResvOk),
    .busy_o       (busy_vec),
    .busy_count_o (bus.busyCount)
  );

  // Read port S: stored value, overridden by the in-flight write when
  // bypassing, and finally forced to zero for the hardwired register.
  always_comb begin
    bus.dataRS = regs_q[bus.RS];
    bus.busyRS = busy_vec[bus.RS];
    if (BYPASS && wr_en && (bus.RD == bus.RS)) begin
      bus.dataRS = bus.dataRD;
      bus.busyRS = 1'b0;
    end
    if (ZERO_REG && (bus.RS == '0)) begin
      bus.dataRS = '0;
      bus.busyRS = 1'b0;
    end
  end

  // Read port T: same rules as port S.
  always_comb begin
    bus.dataRT = regs_q[bus.RT];
    bus.busyRT = busy_vec[bus.RT];
    if (BYPASS && wr_en && (bus.RD == bus.RT)) begin
      bus.dataRT = bus.dataRD;
      bus.busyRT = 1'b0;
    end
    if (ZERO_REG && (bus.RT == '0)) begin
      bus.dataRT = '0;
      bus.busyRT = 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_regfile_scoreboard
// Two instances: u0 (32-bit, 32 regs, zero reg, bypass) and
// u1 (16-bit, 8 regs, no zero reg, no bypass). A reference model of each is
// kept as plain arrays and compared against the DUT outputs every cycle;
// directed steps add literal expectations, then random traffic follows.
// -----------------------------------------------------------------------------
module tb_regfile_scoreboard;

  logic Clk = 1'b0;
  logic Clr;

  always #5 Clk = ~Clk;

  regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5)) if0 ();
  regfile_scoreboard_if #(.DATA_W(16), .ADDR_W(3)) if1 ();

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) u0 (
    .Clk (Clk), .Clr (Clr), .bus (if0)
  );

  regfile_scoreboard #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b0), .BYPASS(1'b0)) u1 (
    .Clk (Clk), .Clr (Clr), .bus (if1)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mreg  [2][32];
  bit          mbusy [2][32];
  bit          mvalid = 1'b0;

  task automatic exp_read(input int u, input bit zr, input bit bp, input bit wr,
                          input int rd, input logic [31:0] din, input int idx,
                          output logic [31:0] d, output bit b);
    d = mreg[u][idx];
    b = mbusy[u][idx];
    if (bp && wr && rd == idx) begin
      d = din;
      b = 1'b0;
    end
    if (zr && idx == 0) begin
      d = 0;
      b = 1'b0;
    end
  endtask

  task automatic model_unit(input int u, input int aw, input bit zr, input bit bp,
                            input int dw,
                            input int rs, input int rt, input int rd,
                            input logic [31:0] din, input bit rw, input bit ren,
                            input int ra,
                            input logic [31:0] a_drs, input logic [31:0] a_drt,
                            input logic a_brs, input logic a_brt, input logic a_ok,
                            input logic [31:0] a_cnt, input bit do_cmp);
    logic [31:0] e_drs, e_drt, dmask;
    bit          e_brs, e_brt, e_ok, wr;
    int          e_cnt;
    string       p;
    p     = $sformatf("u%0d", u);
    dmask = (dw == 32) ? 32'hFFFF_FFFF : ((32'h1 << dw) - 1);
    wr    = rw && !Clr && !(zr && rd == 0);
    exp_read(u, zr, bp, wr, rd, din & dmask, rs, e_drs, e_brs);
    exp_read(u, zr, bp, wr, rd, din & dmask, rt, e_drt, e_brt);
    e_ok  = ren && !Clr && (!mbusy[u][ra] || (rw && rd == ra));
    e_cnt = 0;
    for (int i = 0; i < (1 << aw); i++) e_cnt += int'(mbusy[u][i]);
    if (do_cmp) begin
      chk({p, " dataRS"},    a_drs, e_drs);
      chk({p, " dataRT"},    a_drt, e_drt);
      chk({p, " busyRS"},    {31'b0, a_brs}, {31'b0, e_brs});
      chk({p, " busyRT"},    {31'b0, a_brt}, {31'b0, e_brt});
      chk({p, " ResvOk"},    {31'b0, a_ok},  {31'b0, e_ok});
      chk({p, " busyCount"}, a_cnt, e_cnt);
    end
    if (Clr) begin
      for (int i = 0; i < 32; i++) begin
        mreg[u][i]  = 0;
        mbusy[u][i] = 1'b0;
      end
    end else begin
      if (wr) begin
        mreg[u][rd]  = din & dmask;
        mbusy[u][rd] = 1'b0;
      end
      if (e_ok && !(zr && ra == 0)) mbusy[u][ra] = 1'b1;
    end
  endtask

  always @(negedge Clk) begin
    model_unit(0, 5, 1'b1, 1'b1, 32,
               int'(if0.RS), int'(if0.RT), int'(if0.RD), if0.dataRD,
               if0.RW, if0.ResvEn, int'(if0.ResvAddr),
               if0.dataRS, if0.dataRT, if0.busyRS, if0.busyRT, if0.ResvOk,
               {26'b0, if0.busyCount}, mvalid);
    model_unit(1, 3, 1'b0, 1'b0, 16,
               int'(if1.RS), int'(if1.RT), int'(if1.RD), {16'b0, if1.dataRD},
               if1.RW, if1.ResvEn, int'(if1.ResvAddr),
               {16'b0, if1.dataRS}, {16'b0, if1.dataRT}, if1.busyRS, if1.busyRT,
               if1.ResvOk, {28'b0, if1.busyCount}, mvalid);
    if (Clr) mvalid = 1'b1;
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    Clr = 1'b0;
    if0.RS = '0; if0.RT = '0; if0.RD = '0; if0.dataRD = '0;
    if0.RW = 1'b0; if0.ResvEn = 1'b0; if0.ResvAddr = '0;
    if1.RS = '0; if1.RT = '0; if1.RD = '0; if1.dataRD = '0;
    if1.RW = 1'b0; if1.ResvEn = 1'b0; if1.ResvAddr = '0;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    Clr = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    idle();

    // Reset state
    if0.RS = 5'd3; if0.RT = 5'd31; if1.RS = 3'd3;
    #2;
    chk("rst dataRS", if0.dataRS, 32'h0);
    chk("rst dataRT", if0.dataRT, 32'h0);
    chk("rst busyRS", {31'b0, if0.busyRS}, 32'h0);
    chk("rst busyRT", {31'b0, if0.busyRT}, 32'h0);
    chk("rst busyCount", {26'b0, if0.busyCount}, 32'h0);
    chk("rst ResvOk", {31'b0, if0.ResvOk}, 32'h0);

    // Bypass on u0, stored-only on u1
    step();
    if0.RW = 1'b1; if0.RD = 5'd5; if0.dataRD = 32'hDEADBEEF; if0.RS = 5'd5;
    if1.RW = 1'b1; if1.RD = 3'd6; if1.dataRD = 16'hABCD;     if1.RS = 3'd6;
    #2;
    chk("bypass dataRS", if0.dataRS, 32'hDEADBEEF);
    chk("nobypass dataRS", {16'b0, if1.dataRS}, 32'h0);

    step();
    if0.RS = 5'd5; if1.RS = 3'd6;
    #2;
    chk("stored dataRS", if0.dataRS, 32'hDEADBEEF);
    chk("u1 stored dataRS", {16'b0, if1.dataRS}, 32'h0000ABCD);

    // Zero register
    step();
    if0.RW = 1'b1; if0.RD = 5'd0; if0.dataRD = 32'h1234; if0.RS = 5'd0;
    if0.ResvEn = 1'b1; if0.ResvAddr = 5'd0;
    #2;
    chk("zero dataRS", if0.dataRS, 32'h0);
    chk("zero ResvOk", {31'b0, if0.ResvOk}, 32'h1);

    step();
    if0.RS = 5'd0;
    #2;
    chk("zero dataRS next", if0.dataRS, 32'h0);
    chk("zero busyCount", {26'b0, if0.busyCount}, 32'h0);

    // Reservation of register 7
    step();
    if0.ResvEn = 1'b1; if0.ResvAddr = 5'd7;
    #2;
    chk("resv7 ResvOk", {31'b0, if0.ResvOk}, 32'h1);

    step();
    if0.ResvEn = 1'b1; if0.ResvAddr = 5'd7; if0.RS = 5'd7;
    #2;
    chk("resv7 busyRS", {31'b0, if0.busyRS}, 32'h1);
    chk("resv7 busyCount", {26'b0, if0.busyCount}, 32'h1);
    chk("resv7 again ResvOk", {31'b0, if0.ResvOk}, 32'h0);

    step();
    if0.RW = 1'b1; if0.RD = 5'd7; if0.dataRD = 32'h77;
    if0.ResvEn = 1'b1; if0.ResvAddr = 5'd7;
    #2;
    chk("wr+resv7 ResvOk", {31'b0, if0.ResvOk}, 32'h1);

    step();
    if0.RS = 5'd7;
    #2;
    chk("wr+resv7 busyRS", {31'b0, if0.busyRS}, 32'h1);
    chk("wr+resv7 busyCount", {26'b0, if0.busyCount}, 32'h1);
    chk("wr+resv7 dataRS", if0.dataRS, 32'h77);

    // Reserve 2 (with write), 3, 4, then Clr with a pending write
    step();
    if0.ResvEn = 1'b1; if0.ResvAddr = 5'd2;
    if0.RW = 1'b1; if0.RD = 5'd2; if0.dataRD = 32'h55;
    #2;
    chk("resv2 ResvOk", {31'b0, if0.ResvOk}, 32'h1);

    step();
    if0.ResvEn = 1'b1; if0.ResvAddr = 5'd3; if0.RS = 5'd2;
    #2;
    chk("resv2 dataRS", if0.dataRS, 32'h55);
    chk("resv2 busyRS", {31'b0, if0.busyRS}, 32'h1);
    chk("resv2 busyCount", {26'b0, if0.busyCount}, 32'h2);

    step();
    if0.ResvEn = 1'b1; if0.ResvAddr = 5'd4;

    step();
    Clr = 1'b1;
    if0.RW = 1'b1; if0.RD = 5'd2; if0.dataRD = 32'h99; if0.RS = 5'd2;
    if0.ResvEn = 1'b1; if0.ResvAddr = 5'd5;
    #2;
    chk("clr no bypass dataRS", if0.dataRS, 32'h55);
    chk("clr ResvOk", {31'b0, if0.ResvOk}, 32'h0);
    chk("pre-clr busyCount", {26'b0, if0.busyCount}, 32'h4);

    step();
    if0.RS = 5'd2; if0.RT = 5'd4;
    #2;
    chk("post-clr busyCount", {26'b0, if0.busyCount}, 32'h0);
    chk("post-clr dataRS", if0.dataRS, 32'h0);
    chk("post-clr busyRS", {31'b0, if0.busyRS}, 32'h0);
    chk("post-clr busyRT", {31'b0, if0.busyRT}, 32'h0);

    // Random traffic; small address window half the time to force collisions
    for (int n = 0; n < 2000; n++) begin
      step();
      Clr = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 1) == 1) begin
        if0.RS = 5'($urandom_range(0, 7));  if0.RT = 5'($urandom_range(0, 7));
        if0.RD = 5'($urandom_range(0, 7));  if0.ResvAddr = 5'($urandom_range(0, 7));
      end else begin
        if0.RS = 5'($urandom); if0.RT = 5'($urandom);
        if0.RD = 5'($urandom); if0.ResvAddr = 5'($urandom);
      end
      if0.dataRD = $urandom;
      if0.RW     = ($urandom_range(0, 2) == 0);
      if0.ResvEn = ($urandom_range(0, 1) == 0);
      if1.RS = 3'($urandom); if1.RT = 3'($urandom);
      if1.RD = 3'($urandom); if1.ResvAddr = 3'($urandom);
      if1.dataRD = 16'($urandom);
      if1.RW     = ($urandom_range(0, 2) == 0);
      if1.ResvEn = ($urandom_range(0, 1) == 0);
    end

    step();
    @(negedge Clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
